// File: rtl/down_count_mon_pkg.sv
// Shared types and constants for the down-counter sequence monitor.
package down_count_mon_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_t;

  localparam int ERR_CNT_W = 4;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 4'd15;

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/down_count_monitor_seq_step_check.sv
// Combinational single-step legality check of a T-flip-flop down counter.
module seq_step_check
  import down_count_mon_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev_count,
  input  logic             prev_t,
  input  logic [WIDTH-1:0] count,
  output logic             match,
  output logic             wrap
);

  logic [WIDTH-1:0] expected_s;

  // Expected next sample: hold when disabled, decrement modulo 2^WIDTH when enabled.
  always_comb begin
    expected_s = prev_count;
    if (prev_t) begin
      expected_s = prev_count - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      expected_s = prev_count;
    end
    match = (count == expected_s);
    wrap  = prev_t && (prev_count == {WIDTH{1'b0}}) && (count == {WIDTH{1'b1}});
  end

endmodule

// File: rtl/down_count_monitor.sv
// Sequence monitor and borrow stage for a down counter.
// Optional macro DOWN_COUNT_MON_SAT_EN makes period_cnt saturate instead of wrap.
module down_count_monitor
  import down_count_mon_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int PERIOD_W  = 8,
  parameter int ERR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 t,
  input  logic [WIDTH-1:0]     count,
  input  logic                 clr,
  output logic                 borrow,
  output logic [PERIOD_W-1:0]  period_cnt,
  output logic                 locked,
  output logic                 seq_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [ERR_CNT_W-1:0] ERR_LIMIT_V = ERR_CNT_W'(ERR_LIMIT);

  mon_state_t           state_q, state_d;
  logic                 borrow_q, borrow_d;
  logic [PERIOD_W-1:0]  period_cnt_q, period_cnt_d;
  logic                 locked_q, locked_d;
  logic                 seq_err_q, seq_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH-1:0]     prev_count_q;
  logic                 prev_t_q;

  logic                 match_s;
  logic                 wrap_s;
  logic [ERR_CNT_W-1:0] err_inc_s;
  logic [PERIOD_W-1:0]  period_next_s;

  seq_step_check #(.WIDTH(WIDTH)) u_step (
    .prev_count (prev_count_q),
    .prev_t     (prev_t_q),
    .count      (count),
    .match      (match_s),
    .wrap       (wrap_s)
  );

  assign err_inc_s = sat_inc_err(err_cnt_q);

`ifdef DOWN_COUNT_MON_SAT_EN
  assign period_next_s = (period_cnt_q == {PERIOD_W{1'b1}}) ? period_cnt_q
                       : period_cnt_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
`else
  assign period_next_s = period_cnt_q + {{(PERIOD_W-1){1'b0}}, 1'b1};
`endif

  // Next-state logic: clr overrides the FSM; only TRACK compares samples.
  always_comb begin
    state_d      = state_q;
    borrow_d     = 1'b0;
    period_cnt_d = period_cnt_q;
    seq_err_d    = seq_err_q;
    err_cnt_d    = err_cnt_q;
    if (clr) begin
      seq_err_d = 1'b0;
      err_cnt_d = {ERR_CNT_W{1'b0}};
      state_d   = SYNC;
    end else begin
      case (state_q)
        SYNC: begin
          state_d = TRACK;
        end
        TRACK: begin
          if (!match_s) begin
            seq_err_d = 1'b1;
            err_cnt_d = err_inc_s;
            state_d   = (err_inc_s >= ERR_LIMIT_V) ? FAULT : SYNC;
          end else if (wrap_s) begin
            borrow_d     = 1'b1;
            period_cnt_d = period_next_s;
          end else begin
            borrow_d = 1'b0;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end
    locked_d = (state_d == TRACK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      borrow_q     <= 1'b0;
      period_cnt_q <= {PERIOD_W{1'b0}};
      locked_q     <= 1'b0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= {ERR_CNT_W{1'b0}};
      prev_count_q <= {WIDTH{1'b0}};
      prev_t_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      borrow_q     <= borrow_d;
      period_cnt_q <= period_cnt_d;
      locked_q     <= locked_d;
      seq_err_q    <= seq_err_d;
      err_cnt_q    <= err_cnt_d;
      prev_count_q <= count;
      prev_t_q     <= t;
    end
  end

  assign borrow     = borrow_q;
  assign period_cnt = period_cnt_q;
  assign locked     = locked_q;
  assign seq_err    = seq_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// Randomised self-checking bench for down_count_monitor against a behavioural model.
module tb_down_count_monitor;

  localparam int WIDTH     = 4;
  localparam int PERIOD_W  = 8;
  localparam int ERR_LIMIT = 3;
  localparam int CMOD      = 1 << WIDTH;
  localparam int PMOD      = 1 << PERIOD_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                t = 1'b0;
  logic                clr = 1'b0;
  logic [WIDTH-1:0]    count = '0;
  logic                borrow;
  logic [PERIOD_W-1:0] period_cnt;
  logic                locked;
  logic                seq_err;
  logic [3:0]          err_cnt;

  down_count_monitor #(.WIDTH(WIDTH), .PERIOD_W(PERIOD_W), .ERR_LIMIT(ERR_LIMIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .t          (t),
    .count      (count),
    .clr        (clr),
    .borrow     (borrow),
    .period_cnt (period_cnt),
    .locked     (locked),
    .seq_err    (seq_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: "tracking" means a seed sample is held and comparisons are live.
  int m_prev = 0, m_prev_t = 0, m_tracking = 0, m_fault = 0;
  int m_borrow = 0, m_period = 0, m_serr = 0, m_ecnt = 0;

  int ctr = 15;      // the legal counter value the real hardware would present
  int n_borrow = 0;  // borrow pulses seen from the DUT

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic tv, input logic cv, input int cnt);
    int exp_v;
    if (r) begin
      m_prev = 0; m_prev_t = 0; m_tracking = 0; m_fault = 0;
      m_borrow = 0; m_period = 0; m_serr = 0; m_ecnt = 0;
    end else begin
      m_borrow = 0;
      if (cv) begin
        m_serr = 0; m_ecnt = 0; m_tracking = 0; m_fault = 0;
      end else if (m_fault != 0) begin
        m_fault = 1;
      end else if (m_tracking == 0) begin
        m_tracking = 1;
      end else begin
        exp_v = (m_prev_t != 0) ? (m_prev + CMOD - 1) % CMOD : m_prev;
        if (cnt != exp_v) begin
          m_serr = 1;
          if (m_ecnt < 15) m_ecnt++;
          m_tracking = 0;
          if (m_ecnt >= ERR_LIMIT) m_fault = 1;
        end else if (m_prev_t != 0 && m_prev == 0) begin
          m_borrow = 1;
`ifdef DOWN_COUNT_MON_SAT_EN
          if (m_period < PMOD - 1) m_period++;
`else
          m_period = (m_period + 1) % PMOD;
`endif
        end
      end
      m_prev   = cnt;
      m_prev_t = tv;
    end
  endtask

  // One clock: drive on the falling edge, update model at the rising edge, check 1 ns later.
  task automatic step(input logic r, input logic tv, input logic cv, input int cnt);
    @(negedge clk);
    rst = r; t = tv; clr = cv; count = cnt[WIDTH-1:0];
    @(posedge clk);
    model(r, tv, cv, cnt);
    #1;
    chk("borrow", int'(borrow), m_borrow);
    chk("period_cnt", int'(period_cnt), m_period);
    chk("locked", int'(locked), (m_tracking != 0 && m_fault == 0) ? 1 : 0);
    chk("seq_err", int'(seq_err), m_serr);
    chk("err_cnt", int'(err_cnt), m_ecnt);
    if (borrow === 1'b1) n_borrow++;
  endtask

  // Present either the legal counter value or a corrupted one, then advance the counter.
  task automatic run(input logic r, input logic tv, input logic cv, input logic bad);
    int cnt;
    cnt = bad ? (ctr + int'($urandom_range(1, CMOD - 1))) % CMOD : ctr;
    step(r, tv, cv, cnt);
    if (tv) ctr = (ctr + CMOD - 1) % CMOD;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < CMOD && ctr != target; i++) run(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  int saved_period;
  int saved_borrow;

  initial begin
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_period", int'(period_cnt), 0);

    // Legal down-count from 1111 for 40 cycles: two wraps.
    n_borrow = 0;
    repeat (40) run(1'b0, 1'b1, 1'b0, 1'b0);
    chk("p1_borrows", n_borrow, 2);
    chk("p1_period", int'(period_cnt), 2);
    chk("p1_locked", int'(locked), 1);

    // t pattern 1,0,0,1 with the counter holding while disabled.
    for (int i = 0; i < 40; i++) run(1'b0, (i % 4 == 0 || i % 4 == 3), 1'b0, 1'b0);
    chk("hold_seq_err", int'(seq_err), 0);

    // Single bad sample 0101 -> 0010.
    run_to(5);
    run(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2);
    ctr = 3;
    chk("bad_seq_err", int'(seq_err), 1);
    chk("bad_err_cnt", int'(err_cnt), 1);
    chk("bad_unlock", int'(locked), 0);
    run(1'b0, 1'b1, 1'b0, 1'b0);
    chk("bad_relock", int'(locked), 1);

    // Two more errors reach the fault limit.
    run(1'b0, 1'b1, 1'b0, 1'b1);
    run(1'b0, 1'b1, 1'b0, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b1);
    chk("fault_err_cnt", int'(err_cnt), 3);
    chk("fault_locked", int'(locked), 0);
    saved_period = m_period;
    saved_borrow = n_borrow;
    repeat (40) run(1'b0, 1'b1, 1'b0, 1'b0);
    chk("fault_no_borrow", n_borrow, saved_borrow);
    chk("fault_period_frozen", int'(period_cnt), saved_period);
    run(1'b0, 1'b1, 1'b1, 1'b0);
    chk("clr_err_cnt", int'(err_cnt), 0);
    chk("clr_seq_err", int'(seq_err), 0);
    run(1'b0, 1'b1, 1'b0, 1'b0);
    chk("clr_relock", int'(locked), 1);

    // Mismatch coinciding with clr: clr wins.
    run(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clr_vs_err", int'(err_cnt), 0);
    run(1'b0, 1'b1, 1'b0, 1'b0);

    // 0 -> all-ones while held is an error, never a borrow.
    run_to(0);
    run(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, CMOD - 1);
    chk("held_wrap_borrow", int'(borrow), 0);
    chk("held_wrap_err", int'(seq_err), 1);
    run(1'b0, 1'b1, 1'b1, 1'b0);
    run(1'b0, 1'b1, 1'b0, 1'b0);

    // Reset for three cycles at 0000 just before a wrap.
    run_to(0);
    repeat (3) run(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_borrow", int'(borrow), 0);
    chk("rst_period", int'(period_cnt), 0);
    run(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rst_sync", int'(locked), 1);

    // Randomised mix of enables, corrupted samples, clears and resets.
    for (int i = 0; i < 1500; i++) begin
      run(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 24) == 0));
    end

    // Long legal run so period_cnt crosses its all-ones boundary.
    run(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < CMOD * (PMOD + 4); i++) run(1'b0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
